// File: rtl/l2_cache_nway_if.sv
// Line-granular request bus (L1 arbiter side) and physical memory bus of the L2 cache.
// slave = the cache; master = whatever drives requests and serves pmem.
interface l2_cache_nway_if;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, pmem_resp, pmem_rdata,
    output mem_rdata, mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, pmem_resp, pmem_rdata,
    input  mem_rdata, mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/l2_cache_nway.sv
// N-way set-associative write-back/write-allocate L2 with tree-PLRU replacement.
// Define L2_PERF_COUNTERS_EN to add hit/miss/writeback counters.
module l2_cache_nway #(
  parameter int S_OFFSET = 5,
  parameter int S_INDEX  = 3,
  parameter int WAYS     = 4,
  parameter int S_TAG    = 32 - S_OFFSET - S_INDEX
) (
  input  logic           clk,
  input  logic           rst,
  l2_cache_nway_if.slave bus
`ifdef L2_PERF_COUNTERS_EN
  ,
  output logic [31:0]    hit_count,
  output logic [31:0]    miss_count,
  output logic [31:0]    wb_count
`endif
);
  localparam int SETS = 2 ** S_INDEX;
  localparam int LVLS = $clog2(WAYS);
  localparam int WB_W = (WAYS > 1) ? LVLS : 1;
  localparam int PW   = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic [2:0] {S_IDLE, S_COMPARE, S_WRITEBACK, S_FILL, S_RESPOND} state_t;
  state_t r_state, w_next;

  logic [255:0]       r_data  [WAYS][SETS];
  logic [S_TAG-1:0]   r_tag   [WAYS][SETS];
  logic [WAYS-1:0]    r_valid [SETS];
  logic [WAYS-1:0]    r_dirty [SETS];
  logic [PW-1:0]      r_plru  [SETS];

  logic [S_INDEX-1:0] r_idx;
  logic [S_TAG-1:0]   r_req_tag;
  logic               r_write;
  logic [255:0]       r_wdata;
  logic [WB_W-1:0]    r_way;   // hit way, or the victim while a miss is serviced
  logic [255:0]       r_rdata;

  logic               w_hit, w_has_inv, w_vdirty;
  logic [WB_W-1:0]    w_hit_way, w_inv_way, w_plru_way, w_victim;
  logic [PW-1:0]      w_plru_upd;
  logic               w_unused;

  assign w_unused = ^bus.mem_address[S_OFFSET-1:0];

  always_comb begin
    w_hit = 1'b0;
    w_hit_way = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (r_valid[r_idx][WB_W'(w)] && r_tag[WB_W'(w)][r_idx] == r_req_tag) begin
        w_hit = 1'b1;
        w_hit_way = WB_W'(w);
      end
    // Descending scan so the lowest-index invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--)
      if (!r_valid[r_idx][WB_W'(w)]) begin
        w_has_inv = 1'b1;
        w_inv_way = WB_W'(w);
      end
  end

  // Walk the heap-ordered tree (node n has children 2n, 2n+1) following the node bits.
  always_comb begin
    int node;
    node = 1;
    for (int l = 0; l < LVLS; l++)
      node = 2 * node + int'(|((r_plru[r_idx] >> (node - 1)) & PW'(1)));
    w_plru_way = WB_W'(node - WAYS);
    w_victim = w_has_inv ? w_inv_way : w_plru_way;
    w_vdirty = r_valid[r_idx][w_victim] & r_dirty[r_idx][w_victim];
  end

  // On access, every node on the path is pointed at the sibling subtree.
  always_comb begin
    int   node;
    logic d;
    w_plru_upd = r_plru[r_idx];
    node = 1;
    d = 1'b0;
    for (int l = 0; l < LVLS; l++) begin
      d = |((r_way >> (LVLS - 1 - l)) & WB_W'(1));
      w_plru_upd = (w_plru_upd & ~(PW'(1) << (node - 1))) | (PW'(!d) << (node - 1));
      node = 2 * node + int'(d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (bus.mem_read || bus.mem_write) w_next = S_COMPARE;
      S_COMPARE:   w_next = w_hit ? S_RESPOND : (w_vdirty ? S_WRITEBACK : S_FILL);
      S_WRITEBACK: if (bus.pmem_resp) w_next = S_FILL;
      S_FILL:      if (bus.pmem_resp) w_next = S_COMPARE;
      S_RESPOND:   w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_resp     = (r_state == S_RESPOND);
    bus.mem_rdata    = r_rdata;
    bus.pmem_read    = (r_state == S_FILL);
    bus.pmem_write   = (r_state == S_WRITEBACK);
    bus.pmem_wdata   = r_data[r_way][r_idx];
    bus.pmem_address = '0;
    if (r_state == S_WRITEBACK)
      bus.pmem_address = {r_tag[r_way][r_idx], r_idx, {S_OFFSET{1'b0}}};
    else if (r_state == S_FILL)
      bus.pmem_address = {r_req_tag, r_idx, {S_OFFSET{1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_plru[s]  <= '0;
      end
      r_idx     <= '0;
      r_req_tag <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_way     <= '0;
      r_rdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE:
          if (bus.mem_read || bus.mem_write) begin
            r_idx     <= bus.mem_address[S_OFFSET +: S_INDEX];
            r_req_tag <= bus.mem_address[31 -: S_TAG];
            r_write   <= bus.mem_write;
            r_wdata   <= bus.mem_wdata;
          end
        S_COMPARE:
          if (w_hit) begin
            r_way <= w_hit_way;
            if (r_write) r_dirty[r_idx][w_hit_way] <= 1'b1;
            else         r_rdata <= r_data[w_hit_way][r_idx];
          end else begin
            r_way <= w_victim;
          end
        S_WRITEBACK: if (bus.pmem_resp) r_dirty[r_idx][r_way] <= 1'b0;
        S_FILL:
          if (bus.pmem_resp) begin
            r_valid[r_idx][r_way] <= 1'b1;
            r_dirty[r_idx][r_way] <= 1'b0;
          end
        S_RESPOND: r_plru[r_idx] <= w_plru_upd;
        default: ;
      endcase
    end
  end

  // Line and tag storage carry no reset; validity alone qualifies them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_COMPARE && w_hit && r_write)
        r_data[w_hit_way][r_idx] <= r_wdata;
      else if (r_state == S_FILL && bus.pmem_resp) begin
        r_data[r_way][r_idx] <= bus.pmem_rdata;
        r_tag[r_way][r_idx]  <= r_req_tag;
      end
    end
  end

`ifdef L2_PERF_COUNTERS_EN
  logic r_filled;  // the COMPARE now running is the guaranteed hit after a fill
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
      r_filled   <= 1'b0;
    end else begin
      if (r_state == S_IDLE) r_filled <= 1'b0;
      if (r_state == S_FILL && bus.pmem_resp) r_filled <= 1'b1;
      if (r_state == S_COMPARE && !r_filled) begin
        if (w_hit) hit_count  <= hit_count + 32'd1;
        else       miss_count <= miss_count + 32'd1;
      end
      if (r_state == S_WRITEBACK && bus.pmem_resp) wb_count <= wb_count + 32'd1;
    end
  end
`endif

  a_req_held: assert property (@(posedge clk) disable iff (rst)
    (r_state != S_IDLE) |-> (bus.mem_read || bus.mem_write));
endmodule

// File: tb/tb_l2_cache_nway.sv
// Scoreboarded bench for l2_cache_nway: directed fills, hits, PLRU eviction and reset abort.
module tb_l2_cache_nway;
  localparam int LAT = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l2_cache_nway_if bus();
`ifdef L2_PERF_COUNTERS_EN
  logic [31:0] hit_count, miss_count, wb_count;
`endif

  l2_cache_nway #(.S_OFFSET(5), .S_INDEX(3), .WAYS(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef L2_PERF_COUNTERS_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

  typedef struct packed { logic rd; logic [255:0] data; } mexp_t;
  typedef struct packed { logic wr; logic [31:0] addr; logic [255:0] data; } pexp_t;
  mexp_t mq[$];
  pexp_t pq[$];
  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [255:0] line(input int k);
    return {8{32'hC0DE_0000 | 32'(k)}};
  endfunction
  function automatic logic [255:0] wl(input int k);
    return {8{32'hBEEF_0000 | 32'(k)}};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_i(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // mem-side monitor: every mem_resp must match the oldest outstanding expectation
  initial forever begin
    mexp_t m;
    @(negedge clk);
    if (bus.mem_resp) begin
      chk_i("resp_expected", mq.size() > 0 ? 1 : 0, 1);
      if (mq.size() > 0) begin
        m = mq.pop_front();
        if (m.rd) chk("mem_rdata", bus.mem_rdata, m.data);
      end
    end
  end

  // pmem model and monitor: checks each request, answers LAT cycles after it appears
  initial begin
    pexp_t p;
    bit    aborted;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      if (!rst && (bus.pmem_read || bus.pmem_write)) begin
        chk_i("pmem_expected", pq.size() > 0 ? 1 : 0, 1);
        chk_i("pmem_exclusive", int'(bus.pmem_read & bus.pmem_write), 0);
        if (pq.size() > 0) begin
          p = pq.pop_front();
          chk_i("pmem_is_write", int'(bus.pmem_write), int'(p.wr));
          chk("pmem_address", bus.pmem_address, p.addr);
          if (p.wr) chk("pmem_wdata", bus.pmem_wdata, p.data);
        end else begin
          p = '{wr: bus.pmem_write, addr: bus.pmem_address, data: '0};
        end
        aborted = 1'b0;
        for (int i = 1; i < LAT; i++) begin
          @(negedge clk);
          if (!(bus.pmem_read || bus.pmem_write)) begin
            aborted = 1'b1;
            break;
          end
        end
        if (!aborted) begin
          bus.pmem_resp  = 1'b1;
          bus.pmem_rdata = p.wr ? '0 : p.data;
        end
      end
    end
  end

  task automatic exp_fill(input logic [31:0] a, input logic [255:0] d);
    pq.push_back('{wr: 1'b0, addr: a, data: d});
  endtask
  task automatic exp_wb(input logic [31:0] a, input logic [255:0] d);
    pq.push_back('{wr: 1'b1, addr: a, data: d});
  endtask

  // Hold the request until mem_resp, then drop it right after the closing edge.
  task automatic req(input logic wr, input logic [31:0] a, input logic [255:0] wd, output int cyc);
    @(negedge clk);
    bus.mem_read    = !wr;
    bus.mem_write   = wr;
    bus.mem_address = a;
    bus.mem_wdata   = wd;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.mem_resp && cyc < 200);
    if (!bus.mem_resp) chk_i("req_timeout", cyc, -1);
    @(posedge clk);
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a, input logic [255:0] exp, output int cyc);
    mq.push_back('{rd: 1'b1, data: exp});
    req(1'b0, a, '0, cyc);
  endtask
  task automatic wr(input logic [31:0] a, input logic [255:0] d, output int cyc);
    mq.push_back('{rd: 1'b0, data: '0});
    req(1'b1, a, d, cyc);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_address = '0;
    bus.mem_wdata   = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_resp", bus.mem_resp, 0);
    chk("rst_pmem_read", bus.pmem_read, 0);
    chk("rst_pmem_write", bus.pmem_write, 0);
    chk("rst_pmem_address", bus.pmem_address, 0);
    chk("rst_mem_rdata", bus.mem_rdata, 0);
    rst = 1'b0;

    // Cold read miss, then repeat as a hit.
    exp_fill(32'h1000, line(1));
    rd(32'h0000_1000, line(1), cyc);
    chk_i("clean_miss_latency", cyc, 3 + LAT);
    rd(32'h0000_1000, line(1), cyc);
    chk_i("hit_latency", cyc, 2);

    // Fill set 0; 0x1000 is already resident so its write hits.
    wr(32'h1000, wl(1), cyc);
    chk_i("write_hit_latency", cyc, 2);
    exp_fill(32'h2000, line(2)); wr(32'h2000, wl(2), cyc);
    exp_fill(32'h3000, line(3)); wr(32'h3000, wl(3), cyc);
    exp_fill(32'h4000, line(4)); wr(32'h4000, wl(4), cyc);
    exp_wb(32'h1000, wl(1));
    exp_fill(32'h5000, line(5));
    rd(32'h5000, line(5), cyc);
    chk_i("dirty_miss_latency", cyc, 3 + 2 * LAT);
`ifdef L2_PERF_COUNTERS_EN
    chk("hit_count", hit_count, 2);
    chk("miss_count", miss_count, 5);
    chk("wb_count", wb_count, 1);
`endif
    rd(32'h3000, wl(3), cyc);
    rd(32'h201F, wl(2), cyc);

    // Touching 0x1000 before the last fill moves the victim to 0x2000.
    do_reset();
    exp_fill(32'h1000, line(11)); wr(32'h1000, wl(1), cyc);
    exp_fill(32'h2000, line(12)); wr(32'h2000, wl(2), cyc);
    exp_fill(32'h3000, line(13)); wr(32'h3000, wl(3), cyc);
    rd(32'h1000, wl(1), cyc);
    exp_fill(32'h4000, line(14)); wr(32'h4000, wl(4), cyc);
    exp_wb(32'h2000, wl(2));
    exp_fill(32'h5000, line(15));
    rd(32'h5000, line(15), cyc);
    rd(32'h1000, wl(1), cyc);

    // Reset during a pending fill abandons it; the line must miss afterwards.
    do_reset();
    exp_fill(32'h5000, line(20));
    @(negedge clk);
    bus.mem_read    = 1'b1;
    bus.mem_address = 32'h5000;
    cyc = 0;
    while (!bus.pmem_read && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_fill_started", bus.pmem_read, 1);
    @(negedge clk);
    rst = 1'b1;
    bus.mem_read = 1'b0;
    @(negedge clk);
    chk("abort_pmem_read", bus.pmem_read, 0);
    chk("abort_mem_resp", bus.mem_resp, 0);
    chk("abort_pmem_address", bus.pmem_address, 0);
    rst = 1'b0;
    exp_fill(32'h5000, line(25));
    rd(32'h5000, line(25), cyc);
    chk_i("reread_miss_latency", cyc, 3 + LAT);

    repeat (10) @(negedge clk);
    chk_i("mem_queue_drained", mq.size(), 0);
    chk_i("pmem_queue_drained", pq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
